// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Data wins by default; a bounded data streak keeps a pending fetch from starving.
module mem_port_arbiter #(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    input  logic        i_dm_req,
    input  logic [31:0] i_dm_addr,
    input  logic        i_dm_ren,
    input  logic        i_dm_wen,
    input  logic [31:0] i_dm_wdata,
    input  logic [3:0]  i_dm_mask,
    output logic        o_dm_ready,
    output logic        o_dm_valid,
    output logic [31:0] o_dm_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          own_dm_q;
    logic          own_dm_d;
    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          any_req;
    logic          dm_win;
    logic          grant;
    logic          sel_dm;

    assign any_req = i_if_req | i_dm_req;
    assign dm_win  = i_dm_req & (~i_if_req | (streak_q < STREAK_MAX));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            own_dm_q <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            own_dm_q <= own_dm_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        own_dm_d = own_dm_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    own_dm_d = dm_win;
                    state_d  = i_mem_ready ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (i_mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_mem_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In IDLE the winner is chosen live; afterwards the locked owner drives.
    assign grant  = ((state_q == IDLE) & any_req) | (state_q == ISSUE);
    assign sel_dm = (state_q == IDLE) ? dm_win : own_dm_q;

    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_addr  = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;
        o_mem_mask  = '0;
        o_if_ready  = 1'b0;
        o_dm_ready  = 1'b0;
        o_if_valid  = 1'b0;
        o_if_rdata  = '0;
        o_dm_valid  = 1'b0;
        o_dm_rdata  = '0;
        if (grant) begin
            o_mem_req = 1'b1;
            if (sel_dm) begin
                o_mem_addr  = i_dm_addr;
                o_mem_ren   = i_dm_ren & ~i_dm_wen;
                o_mem_wen   = i_dm_wen;
                o_mem_wdata = i_dm_wdata;
                o_mem_mask  = i_dm_mask;
            end else begin
                o_mem_addr  = i_if_addr;
                o_mem_ren   = 1'b1;
                o_mem_mask  = 4'hF;
            end
            o_if_ready = i_mem_ready & ~sel_dm;
            o_dm_ready = i_mem_ready & sel_dm;
        end
        if ((state_q == RESP) && i_mem_valid) begin
            if (own_dm_q) begin
                o_dm_valid = 1'b1;
                o_dm_rdata = i_mem_rdata;
            end else begin
                o_if_valid = 1'b1;
                o_if_rdata = i_mem_rdata;
            end
        end
    end

    // Streak only matters while a fetch is actually waiting.
    always_comb begin
        streak_d = streak_q;
        if (!i_if_req || o_if_ready) begin
            streak_d = '0;
        end else if (o_dm_ready && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + SW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, grant-order sequence,
// and random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    typedef struct packed {
        logic        rst_n;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic [31:0] dm_addr;
        logic        dm_ren;
        logic        dm_wen;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_mask;
        logic        mem_ready;
        logic        mem_valid;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        if_ready;
        logic        if_valid;
        logic [31:0] if_rdata;
        logic        dm_ready;
        logic        dm_valid;
        logic [31:0] dm_rdata;
        logic        mem_req;
        logic [31:0] mem_addr;
        logic        mem_ren;
        logic        mem_wen;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_mask;
    } out_t;

    typedef struct {
        string nm;
        in_t   i;
        out_t  o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, if_req, dm_req, dm_ren, dm_wen;
    logic        mem_ready, mem_valid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_mask;
    logic        if_ready, if_valid, dm_ready, dm_valid;
    logic        mem_req, mem_ren, mem_wen;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    out_t        dut_o;

    int n_vec = 0;
    int n_bad = 0;

    // Model: at most one outstanding transaction, tracked by who owns it
    // and whether memory has taken the request yet.
    bit m_busy = 0;
    bit m_acc = 0;
    bit m_dm = 0;
    int m_streak = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DM_STREAK(MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_ready(if_ready), .o_if_valid(if_valid), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_addr(dm_addr), .i_dm_ren(dm_ren),
        .i_dm_wen(dm_wen), .i_dm_wdata(dm_wdata), .i_dm_mask(dm_mask),
        .o_dm_ready(dm_ready), .o_dm_valid(dm_valid), .o_dm_rdata(dm_rdata),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_ren(mem_ren),
        .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
        .i_mem_ready(mem_ready), .i_mem_valid(mem_valid),
        .i_mem_rdata(mem_rdata)
    );

    assign dut_o = {if_ready, if_valid, if_rdata, dm_ready, dm_valid,
                    dm_rdata, mem_req, mem_addr, mem_ren, mem_wen,
                    mem_wdata, mem_mask};

    function automatic in_t vi(
        logic [31:0] rs, logic [31:0] ifr, logic [31:0] ia,
        logic [31:0] dmr, logic [31:0] da, logic [31:0] ren,
        logic [31:0] wen, logic [31:0] wd, logic [31:0] mk,
        logic [31:0] rdy, logic [31:0] vld, logic [31:0] rd);
        in_t x;
        x.rst_n = rs[0];      x.if_req = ifr[0];    x.if_addr = ia;
        x.dm_req = dmr[0];    x.dm_addr = da;       x.dm_ren = ren[0];
        x.dm_wen = wen[0];    x.dm_wdata = wd;      x.dm_mask = mk[3:0];
        x.mem_ready = rdy[0]; x.mem_valid = vld[0]; x.mem_rdata = rd;
        return x;
    endfunction

    function automatic out_t vo(
        logic [31:0] ir, logic [31:0] iv, logic [31:0] ird,
        logic [31:0] dr, logic [31:0] dv, logic [31:0] drd,
        logic [31:0] rq, logic [31:0] a, logic [31:0] ren,
        logic [31:0] wen, logic [31:0] wd, logic [31:0] mk);
        out_t o;
        o.if_ready = ir[0]; o.if_valid = iv[0]; o.if_rdata = ird;
        o.dm_ready = dr[0]; o.dm_valid = dv[0]; o.dm_rdata = drd;
        o.mem_req = rq[0];  o.mem_addr = a;     o.mem_ren = ren[0];
        o.mem_wen = wen[0]; o.mem_wdata = wd;   o.mem_mask = mk[3:0];
        return o;
    endfunction

    function automatic bit model_pick_dm(in_t x);
        return x.dm_req && (!x.if_req || m_streak < MAX);
    endfunction

    function automatic out_t model_out(in_t x);
        out_t o;
        bit drive;
        bit dm;
        o = '0;
        drive = 0;
        dm = m_dm;
        if (!m_busy) begin
            if (x.if_req || x.dm_req) begin
                drive = 1;
                dm = model_pick_dm(x);
            end
        end else if (!m_acc) begin
            drive = 1;
        end else if (x.mem_valid) begin
            if (m_dm) begin
                o.dm_valid = 1'b1;
                o.dm_rdata = x.mem_rdata;
            end else begin
                o.if_valid = 1'b1;
                o.if_rdata = x.mem_rdata;
            end
        end
        if (drive) begin
            o.mem_req = 1'b1;
            if (dm) begin
                o.mem_addr  = x.dm_addr;
                o.mem_wen   = x.dm_wen;
                o.mem_ren   = x.dm_ren && !x.dm_wen;
                o.mem_wdata = x.dm_wdata;
                o.mem_mask  = x.dm_mask;
            end else begin
                o.mem_addr = x.if_addr;
                o.mem_ren  = 1'b1;
                o.mem_mask = 4'hF;
            end
            o.dm_ready = dm && x.mem_ready;
            o.if_ready = !dm && x.mem_ready;
        end
        return o;
    endfunction

    function automatic void model_upd(in_t x, out_t o);
        if (!x.rst_n) begin
            m_busy = 0;
            m_acc = 0;
            m_dm = 0;
            m_streak = 0;
            return;
        end
        if (!m_busy) begin
            if (x.if_req || x.dm_req) begin
                m_busy = 1;
                m_dm = model_pick_dm(x);
                m_acc = x.mem_ready;
            end
        end else if (!m_acc) begin
            if (x.mem_ready) m_acc = 1;
        end else if (x.mem_valid) begin
            m_busy = 0;
            m_acc = 0;
        end
        if (!x.if_req || o.if_ready) m_streak = 0;
        else if (o.dm_ready && m_streak < MAX) m_streak++;
    endfunction

    task automatic step(input in_t x, output out_t got, output out_t em);
        rst_n = x.rst_n;         if_req = x.if_req;
        if_addr = x.if_addr;     dm_req = x.dm_req;
        dm_addr = x.dm_addr;     dm_ren = x.dm_ren;
        dm_wen = x.dm_wen;       dm_wdata = x.dm_wdata;
        dm_mask = x.dm_mask;     mem_ready = x.mem_ready;
        mem_valid = x.mem_valid; mem_rdata = x.mem_rdata;
        @(negedge clk);
        got = dut_o;
        em = model_out(x);
        @(posedge clk);
        model_upd(x, em);
        #1;
    endtask

    task automatic check(input string nm, input out_t got, input out_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    vec_t tbl[$];
    bit   exp_dm[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        in_t  x;
        out_t got, em, z;
        int   k;
        z = '0;

        // Unchecked reset cycles to clear the power-up X state.
        x = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(x, got, em);
        step(x, got, em);

        tbl.push_back('{"rst_state", vi(1,0,0,0,0,0,0,0,0,0,0,0), z});
        tbl.push_back('{"t1_req", vi(1,1,'h100,0,0,0,0,0,0,1,0,0),
                        vo(1,0,0,0,0,0,1,'h100,1,0,0,'hF)});
        tbl.push_back('{"t1_rsp", vi(1,0,0,0,0,0,0,0,0,0,1,'hDEADBEEF),
                        vo(0,1,'hDEADBEEF,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{"t1_idle", vi(1,0,0,0,0,0,0,0,0,0,0,0), z});
        tbl.push_back('{"t6_req",
                        vi(1,0,0,1,'h3000,1,1,'hA5A5A5A5,'hC,1,0,0),
                        vo(0,0,0,1,0,0,1,'h3000,0,1,'hA5A5A5A5,'hC)});
        tbl.push_back('{"t6_ack", vi(1,0,0,0,0,0,0,0,0,0,1,'h55),
                        vo(0,0,0,0,1,'h55,0,0,0,0,0,0)});
        tbl.push_back('{"t2_dm",
                        vi(1,1,'h104,1,'h2000,0,1,'h11223344,'hF,1,0,0),
                        vo(0,0,0,1,0,0,1,'h2000,0,1,'h11223344,'hF)});
        tbl.push_back('{"t2_dmack", vi(1,1,'h104,0,0,0,0,0,0,1,1,0),
                        vo(0,0,0,0,1,0,0,0,0,0,0,0)});
        tbl.push_back('{"t2_if", vi(1,1,'h104,0,0,0,0,0,0,1,0,0),
                        vo(1,0,0,0,0,0,1,'h104,1,0,0,'hF)});
        tbl.push_back('{"t2_ifrsp", vi(1,0,0,0,0,0,0,0,0,0,1,'h13),
                        vo(0,1,'h13,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{"t4_c0", vi(1,1,'h200,0,0,0,0,0,0,0,0,0),
                        vo(0,0,0,0,0,0,1,'h200,1,0,0,'hF)});
        tbl.push_back('{"t4_c1", vi(1,1,'h200,1,'h4000,1,0,0,'hF,0,0,0),
                        vo(0,0,0,0,0,0,1,'h200,1,0,0,'hF)});
        tbl.push_back('{"t4_c2", vi(1,1,'h200,1,'h4000,1,0,0,'hF,0,0,0),
                        vo(0,0,0,0,0,0,1,'h200,1,0,0,'hF)});
        tbl.push_back('{"t4_c3", vi(1,1,'h200,1,'h4000,1,0,0,'hF,1,0,0),
                        vo(1,0,0,0,0,0,1,'h200,1,0,0,'hF)});
        tbl.push_back('{"t4_ifrsp", vi(1,0,0,1,'h4000,1,0,0,'hF,0,1,'h77),
                        vo(0,1,'h77,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{"t4_dm", vi(1,0,0,1,'h4000,1,0,0,'hF,1,0,0),
                        vo(0,0,0,1,0,0,1,'h4000,1,0,0,'hF)});
        tbl.push_back('{"t4_dmrsp", vi(1,0,0,0,0,0,0,0,0,0,1,'h99),
                        vo(0,0,0,0,1,'h99,0,0,0,0,0,0)});
        tbl.push_back('{"t5_req", vi(1,1,'h300,0,0,0,0,0,0,1,0,0),
                        vo(1,0,0,0,0,0,1,'h300,1,0,0,'hF)});
        tbl.push_back('{"t5_rst", vi(0,0,0,0,0,0,0,0,0,0,0,0), z});
        tbl.push_back('{"t5_late", vi(1,0,0,0,0,0,0,0,0,0,1,'hBAD), z});
        tbl.push_back('{"t5_idle", vi(1,0,0,0,0,0,0,0,0,0,0,0), z});

        foreach (tbl[i]) begin
            step(tbl[i].i, got, em);
            check(tbl[i].nm, got, tbl[i].o);
        end

        // Both requesters held: data wins MAX times, then one fetch.
        x = vi(1, 1, 'h600, 1, 'h5000, 1, 0, 0, 'hF, 1, 1, 'h42);
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            step(x, got, em);
            if (got.if_ready || got.dm_ready) begin
                n_vec++;
                if (got.dm_ready !== exp_dm[k] ||
                    (got.if_ready && got.dm_ready)) begin
                    n_bad++;
                    $display("FAIL grant%0d: if_rdy %b dm_rdy %b want dm %b",
                             k, got.if_ready, got.dm_ready, exp_dm[k]);
                end
                k++;
            end
        end
        if (k < 10) begin
            n_vec++;
            n_bad++;
            $display("FAIL grant_timeout: got %0d grants want 10", k);
        end

        // Random traffic against the model, with occasional resets.
        x = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(x, got, em);
        for (int c = 0; c < 3000; c++) begin
            x.rst_n = ($urandom % 128) != 0;
            if (!x.if_req && ($urandom % 2) == 1) begin
                x.if_req  = 1'b1;
                x.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!x.dm_req && ($urandom % 2) == 1) begin
                x.dm_req   = 1'b1;
                x.dm_addr  = $urandom & 32'hFFFF_FFFC;
                x.dm_ren   = 1'($urandom % 2);
                x.dm_wen   = 1'($urandom % 2);
                x.dm_wdata = $urandom;
                x.dm_mask  = 4'($urandom % 16);
            end
            x.mem_ready = ($urandom % 3) != 0;
            x.mem_valid = 1'($urandom % 2);
            x.mem_rdata = $urandom;
            step(x, got, em);
            check($sformatf("rand%0d", c), got, em);
            if (em.if_ready) x.if_req = 1'b0;
            if (em.dm_ready) x.dm_req = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
